// File: rtl/sumador_restador_bcd_serie_if.sv
// Handshake and operand/result bundle for the digit-serial BCD adder/subtractor.
interface sumador_restador_bcd_serie_if #(
  parameter int N_DIGITOS = 4
);
  logic                   start;
  logic                   mux_suma_resta;
  logic                   Acarreo_in;
  logic [4*N_DIGITOS-1:0] A;
  logic [4*N_DIGITOS-1:0] B;
  logic                   busy;
  logic                   done;
  logic [4*N_DIGITOS-1:0] Z;
  logic                   Acarreo_out;
  logic                   error;

  // Requester side: drives the operation, observes the result.
  modport master (
    output start, mux_suma_resta, Acarreo_in, A, B,
    input  busy, done, Z, Acarreo_out, error
  );

  // Arithmetic unit side.
  modport slave (
    input  start, mux_suma_resta, Acarreo_in, A, B,
    output busy, done, Z, Acarreo_out, error
  );
endinterface

// File: rtl/sumador_restador_bcd_serie.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LSD first.
// Subtraction is A + 10's complement of B (nines' complement plus carry-in 1).
module sumador_restador_bcd_serie #(
  parameter int N_DIGITOS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  sumador_restador_bcd_serie_if.slave   bus
);
  localparam int W  = 4*N_DIGITOS;
  localparam int CW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_sh, b_sh, res, res_n, z_q;
  logic           sub, c, co_q, err_lat, err_q;
  logic           last, bad;
  logic [3:0]     a_d, b_d, b_eff, dig;
  logic [4:0]     s;
  logic           c_n;

  assign last = (cnt == CW'(N_DIGITOS-1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state decode: start only matters in IDLE, DONE always returns to IDLE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = CALC;
      CALC:    if (last)      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One decimal digit step; 5-bit sum tops out at 15+15+1.
  always_comb begin
    a_d   = a_sh[3:0];
    b_d   = b_sh[3:0];
    b_eff = sub ? (4'd9 - b_d) : b_d;
    s     = {1'b0, a_d} + {1'b0, b_eff} + {4'd0, c};
    dig   = s[3:0];
    c_n   = 1'b0;
    if (s > 5'd9) begin
      dig = s[3:0] + 4'd6;
      c_n = 1'b1;
    end
  end

  // Flag any non-decimal digit in the operands about to be latched.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < N_DIGITOS; i++)
      if (bus.A[4*i +: 4] > 4'd9 || bus.B[4*i +: 4] > 4'd9) bad = 1'b1;
  end

  // New digits enter the result from the top so digit 0 lands in [3:0] at the end.
  if (N_DIGITOS == 1) begin : g_res1
    assign res_n = dig;
  end else begin : g_resn
    assign res_n = {dig, res[W-1:4]};
  end

  // Operand/result datapath; published outputs only move on the final digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      z_q     <= '0;
      cnt     <= '0;
      sub     <= 1'b0;
      c       <= 1'b0;
      co_q    <= 1'b0;
      err_lat <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_sh    <= bus.A;
          b_sh    <= bus.B;
          sub     <= bus.mux_suma_resta;
          c       <= bus.mux_suma_resta ? 1'b1 : bus.Acarreo_in;
          cnt     <= '0;
          res     <= '0;
          err_lat <= bad;
        end
        CALC: begin
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          c    <= c_n;
          res  <= res_n;
          cnt  <= cnt + 1'b1;
          if (last) begin
            z_q   <= res_n;
            co_q  <= c_n;
            err_q <= err_lat;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == CALC);
  assign bus.done        = (state == DONE);
  assign bus.Z           = z_q;
  assign bus.Acarreo_out = co_q;
  assign bus.error       = err_q;
endmodule

// File: tb/tb_sumador_restador_bcd_serie.sv
// Bench for the digit-serial BCD adder/subtractor at 4, 1 and 8 digits,
// scoreboarded against a decimal reference model.
module tb_sumador_restador_bcd_serie;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sumador_restador_bcd_serie_if #(.N_DIGITOS(4)) b4();
  sumador_restador_bcd_serie_if #(.N_DIGITOS(1)) b1();
  sumador_restador_bcd_serie_if #(.N_DIGITOS(8)) b8();

  sumador_restador_bcd_serie #(.N_DIGITOS(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
  sumador_restador_bcd_serie #(.N_DIGITOS(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  sumador_restador_bcd_serie #(.N_DIGITOS(8)) u8 (.clk(clk), .reset(reset), .bus(b8));

  typedef struct {
    logic [31:0] z;
    logic        co;
    logic        err;
    logic        val;   // Z/carry only defined for valid operands
  } exp_t;

  exp_t q4[$], q1[$], q8[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int ndig(input int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 1 : 8;
  endfunction

  function automatic longint dec(input logic [31:0] v, input int n);
    longint r = 0;
    for (int i = n-1; i >= 0; i--) r = r*10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input longint v, input int n);
    logic [31:0] r = '0;
    longint      t = v;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference: plain integer add/subtract modulo 10^n.
  function automatic exp_t model(input logic [31:0] a, b, input logic sub, cin, input int n);
    exp_t   e;
    longint av, bv, md, t;
    e.err = 1'b0;
    for (int i = 0; i < n; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) e.err = 1'b1;
    e.val = !e.err;
    md = 1;
    for (int i = 0; i < n; i++) md = md * 10;
    av = dec(a, n);
    bv = dec(b, n);
    if (!sub) begin
      t    = av + bv + longint'(cin);
      e.co = (t >= md);
      e.z  = to_bcd(t % md, n);
    end else if (av >= bv) begin
      e.co = 1'b1;
      e.z  = to_bcd(av - bv, n);
    end else begin
      e.co = 1'b0;
      e.z  = to_bcd(md - (bv - av), n);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, sub, cin, input logic [31:0] a, b);
    case (sel)
      0: begin b4.start = st; b4.mux_suma_resta = sub; b4.Acarreo_in = cin; b4.A = a[15:0]; b4.B = b[15:0]; end
      1: begin b1.start = st; b1.mux_suma_resta = sub; b1.Acarreo_in = cin; b1.A = a[3:0];  b1.B = b[3:0];  end
      default: begin b8.start = st; b8.mux_suma_resta = sub; b8.Acarreo_in = cin; b8.A = a; b8.B = b; end
    endcase
  endtask

  task automatic set_start(input int sel, input logic st);
    case (sel)
      0: b4.start = st;
      1: b1.start = st;
      default: b8.start = st;
    endcase
  endtask

  task automatic sample(input int sel, output logic bs, dn, output logic [31:0] z, output logic co, er);
    case (sel)
      0: begin bs = b4.busy; dn = b4.done; z = {16'd0, b4.Z}; co = b4.Acarreo_out; er = b4.error; end
      1: begin bs = b1.busy; dn = b1.done; z = {28'd0, b1.Z}; co = b1.Acarreo_out; er = b1.error; end
      default: begin bs = b8.busy; dn = b8.done; z = b8.Z; co = b8.Acarreo_out; er = b8.error; end
    endcase
  endtask

  task automatic push(input int sel, input exp_t e);
    case (sel)
      0: q4.push_back(e);
      1: q1.push_back(e);
      default: q8.push_back(e);
    endcase
  endtask

  // Called in a cycle where done is high: pop the oldest expectation and compare.
  task automatic check_done(input int sel);
    exp_t e;
    logic bs, dn, co, er;
    logic [31:0] z;
    int   sz;
    sz = (sel == 0) ? q4.size() : (sel == 1) ? q1.size() : q8.size();
    chk("sb_nonempty", 32'(sz != 0), 32'd1);
    if (sz == 0) return;
    case (sel)
      0: e = q4.pop_front();
      1: e = q1.pop_front();
      default: e = q8.pop_front();
    endcase
    sample(sel, bs, dn, z, co, er);
    if (e.val) begin
      chk("Z", z, e.z);
      chk("Acarreo_out", 32'(co), 32'(e.co));
    end
    chk("error", 32'(er), 32'(e.err));
  endtask

  // Issue one operation and wait (bounded) for done, checking latency and result.
  task automatic run_op(input int sel, input logic [31:0] a, b, input logic sub, cin);
    int   n, lat;
    logic bs, dn, co, er;
    logic [31:0] z;
    n = ndig(sel);
    push(sel, model(a, b, sub, cin, n));
    @(negedge clk);
    drive(sel, 1'b1, sub, cin, a, b);
    @(posedge clk);
    #1 set_start(sel, 1'b0);
    lat = -1;
    for (int cyc = 0; cyc < n + 4; cyc++) begin
      @(negedge clk);
      sample(sel, bs, dn, z, co, er);
      if (dn) begin lat = cyc; break; end
    end
    chk("latency", 32'(lat), 32'(n));
    if (lat >= 0) check_done(sel);
  endtask

  // Wait for done (bounded) and check the scoreboard head.
  task automatic wait_done(input int sel, input int budget);
    logic bs, dn, co, er;
    logic [31:0] z;
    logic seen = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      sample(sel, bs, dn, z, co, er);
      if (dn) begin seen = 1'b1; break; end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) check_done(sel);
  endtask

  initial begin
    logic bs, dn, co, er;
    logic [31:0] z, ra, rb;
    logic [6:0]  busy_v, done_v;

    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #12;
    for (int s = 0; s < 3; s++) begin
      sample(s, bs, dn, z, co, er);
      chk("rst_busy", 32'(bs), 0);
      chk("rst_done", 32'(dn), 0);
      chk("rst_Z", z, 0);
      chk("rst_co", 32'(co), 0);
      chk("rst_err", 32'(er), 0);
    end
    @(negedge clk) reset = 1'b0;

    // Additions, carry ripple, subtractions
    run_op(0, 32'h1234, 32'h5678, 1'b0, 1'b0);
    run_op(0, 32'h9999, 32'h0000, 1'b0, 1'b1);
    run_op(0, 32'h0999, 32'h0001, 1'b0, 1'b0);
    run_op(0, 32'h5000, 32'h1234, 1'b1, 1'b0);
    run_op(0, 32'h1234, 32'h5000, 1'b1, 1'b1);
    run_op(0, 32'h4321, 32'h4321, 1'b1, 1'b0);

    // Invalid digit reported, then cleared by a valid operation
    run_op(0, 32'h00A0, 32'h0001, 1'b0, 1'b0);
    run_op(0, 32'h0042, 32'h0017, 1'b0, 1'b0);

    // start held high: 4 busy, done, one idle, then a new operation
    push(0, model(32'h0123, 32'h0456, 1'b0, 1'b0, 4));
    push(0, model(32'h0123, 32'h0456, 1'b0, 1'b0, 4));
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0123, 32'h0456);
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sample(0, bs, dn, z, co, er);
      busy_v[i] = bs;
      done_v[i] = dn;
      if (dn) check_done(0);
    end
    set_start(0, 1'b0);
    chk("held_busy", 32'(busy_v), 32'b1001111);
    chk("held_done", 32'(done_v), 32'b0010000);
    wait_done(0, 8);

    // start pulse during CALC ignored, operand changes after start have no effect
    run_op(0, 32'h1234, 32'h5678, 1'b0, 1'b0);
    push(0, model(32'h2222, 32'h1111, 1'b0, 1'b0, 4));
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h2222, 32'h1111);
    @(posedge clk);
    #1 set_start(0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h9999, 32'h9876);
    sample(0, bs, dn, z, co, er);
    chk("calc_busy", 32'(bs), 1);
    chk("calc_Z_hold", z, 32'h6912);
    @(posedge clk);
    #1 set_start(0, 1'b0);
    @(negedge clk);
    sample(0, bs, dn, z, co, er);
    chk("calc_Z_hold2", z, 32'h6912);
    wait_done(0, 6);
    @(negedge clk);
    sample(0, bs, dn, z, co, er);
    chk("no_queue_idle1", 32'(bs), 0);
    @(negedge clk);
    sample(0, bs, dn, z, co, er);
    chk("no_queue_idle2", 32'(bs), 0);

    // Asynchronous reset between edges in the middle of CALC
    push(0, model(32'h1111, 32'h2222, 1'b0, 1'b0, 4));
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h1111, 32'h2222);
    @(posedge clk);
    #1 set_start(0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    sample(0, bs, dn, z, co, er);
    chk("arst_busy", 32'(bs), 0);
    chk("arst_done", 32'(dn), 0);
    chk("arst_Z", z, 0);
    chk("arst_co", 32'(co), 0);
    chk("arst_err", 32'(er), 0);
    q4.delete();
    @(negedge clk) reset = 1'b0;
    run_op(0, 32'h1234, 32'h5678, 1'b0, 1'b0);

    // Single digit
    run_op(1, 32'h7, 32'h5, 1'b1, 1'b0);
    run_op(1, 32'h7, 32'h5, 1'b0, 1'b0);
    run_op(1, 32'h3, 32'h8, 1'b1, 1'b0);
    run_op(1, 32'hC, 32'h1, 1'b0, 1'b0);

    // Eight digits: directed edges, then random valid operations
    run_op(2, 32'h99999999, 32'h00000000, 1'b0, 1'b1);
    run_op(2, 32'h00000000, 32'h00000001, 1'b1, 1'b0);
    for (int k = 0; k < 500; k++) begin
      for (int d = 0; d < 8; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      run_op(2, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
